subseq_sum_param: RTL and testbench
===================================

Name: subseq_sum_param

Overview:
- Parametrised streaming maximum-subarray-sum engine; successor to the fixed 8-sample/8-bit subseq_sum.
- Consumes frames of SEQ_LEN signed samples under a valid/ready handshake and runs Kadane's algorithm on the fly.
- Emits a one-cycle result pulse carrying the signed maximum sum; optionally also the start and end indices.
- Adds a run-time mode that allows the empty subarray.

Parameters:
DATA_W, 8, sample width (signed two's complement)
SEQ_LEN, 8, samples per frame, >= 2
SUM_W, 12, result width; must be >= DATA_W + clog2(SEQ_LEN) (elaboration-time check, $error if violated)
IDX_W, clog2(SEQ_LEN), index width (derived, not user-set)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
mode_empty  in  1  0: subarray non-empty; 1: empty subarray (sum 0) permitted; sampled on a frame's first accepted sample
valid_in  in  1  sample valid
data_in  in  DATA_W  signed sample
in_ready  out  1  block accepts a sample this cycle
valid_out  out  1  result valid, one-cycle pulse
max_sum  out  SUM_W  signed maximum subarray sum
start_idx  out  IDX_W  first index of best subarray (SUBSEQ_IDX_EN only)
end_idx  out  IDX_W  last index of best subarray (SUBSEQ_IDX_EN only)
idx_valid  out  1  0 when the result is the empty subarray (SUBSEQ_IDX_EN only)

Behaviour:
- Reset (rst=0, async): state IDLE, counters cleared, valid_out=0, max_sum=0, start_idx=end_idx=0, idx_valid=0, in_ready=1.
- A sample is accepted when valid_in & in_ready. Gaps in valid_in are allowed; no timeout.
- FSM states and transitions:
  - IDLE: in_ready=1. On first accept: latch mode_empty, initialise, go to ACC.
  - ACC: in_ready=1. On the accept of sample SEQ_LEN-1, go to OUT.
  - OUT: one cycle; valid_out=1, in_ready=0; back to IDLE. valid_in in OUT is ignored; the sample is dropped, not queued.
- Latency: valid_out rises exactly one cycle after the clock edge that accepts the last sample. Minimum frame period is SEQ_LEN+1 cycles.
- Arithmetic: samples are sign-extended to SUM_W. Per accepted sample x at index k:
  - cur_new = (k==0 or cur<0) ? x : cur+x; a new run starts at k when that condition holds.
  - best updates only if cur_new > best (strict); earliest subarray wins ties.
- Initial best:
  - mode_empty=0: best=first sample.
  - mode_empty=1: best=0, and the first sample updates best only if it is > 0.
- If best is never updated in mode 1: max_sum=0, idx_valid=0, indices=0.
- No overflow is possible given the SUM_W constraint. Extremes: all +max gives SEQ_LEN*(2^(DATA_W-1)-1); all -max gives -2^(DATA_W-1) in mode 0.
- Output holding: max_sum and the indices update at the OUT entry and hold until the next frame's result or reset. They are only guaranteed meaningful while valid_out=1.
- Reset mid-frame: the partial frame is discarded; the next accepted sample is index 0.
- mode_empty changes mid-frame have no effect until the next frame.

Optional Feature:
SUBSEQ_IDX_EN
- Defined: start_idx, end_idx and idx_valid ports exist; index tracking registers are built.
- Undefined: those ports and registers are absent; max_sum and timing are identical.

Decomposition:
- Package subseq_pkg holds:
  - state enum (IDLE, ACC, OUT)
  - clog2-based width helper
  - function sext_to_sum for sign extension
- Natural sub-module kadane_step: combinational next-cur/next-best/run-start logic for one sample. The top keeps the FSM, counter and output registers.

Test Plan:
- Frame -7,1,-3,2,-1,1,3,-5, mode 0, contiguous -> one valid_out pulse, max_sum=5, start_idx=3, end_idx=6, idx_valid=1; valid_out low the next cycle.
- Frame -3,-1,-4,-2,-8,-5,-6,-7 -> mode 0: max_sum=-1, idx 1..1. Mode 1: max_sum=0, idx_valid=0.
- Frame of all 127 -> 1016, idx 0..7. All -128, mode 0 -> -128, idx 0..0. Random 2-cycle gaps in valid_in -> same results, latency 1 after last accept.
- Back-to-back frames with valid_in held high through OUT -> the sample presented in OUT is dropped (in_ready=0); the second frame starts with the next sample and its result matches the model.
- rst pulled low after 4 samples, released, then full frame 1,2,3,-10,4,5,-1,2 -> no pulse from the aborted frame; max_sum=10, idx 4..7.
- Ties 2,-2,2,-2,0,0,0,0 mode 0 -> max_sum=2, start_idx=0, end_idx=0 (earliest wins). Repeat with SEQ_LEN=16, DATA_W=4 against a reference model.

Source files
------------

// File: rtl/subseq_sum_param_pkg.sv
// subseq_pkg: shared types and helpers for the max-subarray engine.
// FSM states, index width helper and sample sign extension.
package subseq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_e;

  localparam int MAX_W = 64;

  // Index width that never collapses to zero bits.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Sign-extend the low w bits of x to the full helper width.
  function automatic logic signed [MAX_W-1:0] sext_to_sum(
    input logic [MAX_W-1:0] x,
    input int               w
  );
    logic signed [MAX_W-1:0] t;
    t = $signed(x << (MAX_W - w));
    return t >>> (MAX_W - w);
  endfunction

endpackage

// File: rtl/subseq_sum_param_kadane_step.sv
// kadane_step: one Kadane update for a single sample.
// Purely combinational; the caller owns all state.
module kadane_step
  import subseq_pkg::*;
#(
  parameter int SUM_W = 12
) (
  input  logic signed [SUM_W-1:0] x_i,
  input  logic signed [SUM_W-1:0] cur_i,
  input  logic signed [SUM_W-1:0] best_i,
  input  logic                    first_i,
  input  logic                    mode_i,
  output logic signed [SUM_W-1:0] cur_o,
  output logic signed [SUM_W-1:0] best_o,
  output logic                    run_start_o,
  output logic                    best_upd_o
);

  logic x_pos;

  assign x_pos = !x_i[SUM_W-1] && (x_i != '0);

  // New run on the first sample or when the running sum went negative.
  always_comb begin
    run_start_o = first_i | cur_i[SUM_W-1];
    cur_o       = run_start_o ? x_i : cur_i + x_i;
    if (first_i) begin
      best_upd_o = !mode_i || x_pos;
    end else begin
      best_upd_o = cur_o > best_i;
    end
    if (best_upd_o) begin
      best_o = cur_o;
    end else if (first_i) begin
      best_o = '0;
    end else begin
      best_o = best_i;
    end
  end

endmodule

// File: rtl/subseq_sum_param.sv
// subseq_sum_param: streaming max-subarray-sum over SEQ_LEN-sample frames.
// Define SUBSEQ_IDX_EN to add start_idx/end_idx/idx_valid outputs.
module subseq_sum_param
  import subseq_pkg::*;
#(
  parameter int  DATA_W  = 8,
  parameter int  SEQ_LEN = 8,
  parameter int  SUM_W   = 12,
  localparam int IDX_W   = clog2w(SEQ_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_empty,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              in_ready,
  output logic              valid_out,
  output logic [SUM_W-1:0]  max_sum
`ifdef SUBSEQ_IDX_EN
  ,
  output logic [IDX_W-1:0]  start_idx,
  output logic [IDX_W-1:0]  end_idx,
  output logic              idx_valid
`endif
);

  if (SUM_W < DATA_W + $clog2(SEQ_LEN)) begin : g_bad_sum_w
    $error("SUM_W too narrow for DATA_W and SEQ_LEN");
  end

  state_e state_q, state_d;

  logic [IDX_W-1:0] cnt_q;
  logic             mode_q;
  logic signed [SUM_W-1:0] cur_q, best_q, sum_q;
  logic signed [SUM_W-1:0] x_s, cur_d, best_d;
  logic acc, first, last, mode_eff;
  logic run_start, best_upd;

  assign acc      = valid_in & in_ready;
  assign first    = (state_q == IDLE);
  assign last     = (cnt_q == IDX_W'(SEQ_LEN - 1));
  assign mode_eff = first ? mode_empty : mode_q;
  assign x_s      = SUM_W'(sext_to_sum(MAX_W'(data_in), DATA_W));
  assign max_sum  = sum_q;

  kadane_step #(
    .SUM_W(SUM_W)
  ) u_step (
    .x_i        (x_s),
    .cur_i      (cur_q),
    .best_i     (best_q),
    .first_i    (first),
    .mode_i     (mode_eff),
    .cur_o      (cur_d),
    .best_o     (best_d),
    .run_start_o(run_start),
    .best_upd_o (best_upd)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and handshake outputs; OUT lasts one cycle.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b1;
    valid_out = 1'b0;
    unique case (state_q)
      IDLE: if (valid_in) state_d = ACC;
      ACC:  if (valid_in && last) state_d = OUT;
      OUT: begin
        state_d   = IDLE;
        in_ready  = 1'b0;
        valid_out = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Kadane state, sample counter and held result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      cur_q  <= '0;
      best_q <= '0;
      sum_q  <= '0;
    end else if (acc) begin
      cnt_q  <= last ? '0 : cnt_q + IDX_W'(1);
      cur_q  <= cur_d;
      best_q <= best_d;
      if (first) mode_q <= mode_empty;
      if (last)  sum_q  <= best_d;
    end
  end

`ifdef SUBSEQ_IDX_EN
  logic [IDX_W-1:0] rs_q, bs_q, be_q, st_q, en_q;
  logic [IDX_W-1:0] rs_d, bs_d, be_d;
  logic             hit_q, hit_d, iv_q;

  assign start_idx = st_q;
  assign end_idx   = en_q;
  assign idx_valid = iv_q;

  // Track run start and best span for the sample being accepted.
  always_comb begin
    rs_d  = run_start ? cnt_q : rs_q;
    bs_d  = bs_q;
    be_d  = be_q;
    hit_d = hit_q;
    if (best_upd) begin
      bs_d  = rs_d;
      be_d  = cnt_q;
      hit_d = 1'b1;
    end else if (first) begin
      bs_d  = '0;
      be_d  = '0;
      hit_d = 1'b0;
    end
  end

  // Index registers and held index result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_q  <= '0;
      bs_q  <= '0;
      be_q  <= '0;
      hit_q <= 1'b0;
      st_q  <= '0;
      en_q  <= '0;
      iv_q  <= 1'b0;
    end else if (acc) begin
      rs_q  <= rs_d;
      bs_q  <= bs_d;
      be_q  <= be_d;
      hit_q <= hit_d;
      if (last) begin
        st_q <= bs_d;
        en_q <= be_d;
        iv_q <= hit_d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_subseq_sum_param.sv
// tb_subseq_sum_param: directed frames against a brute-force model.
// Checks both the default and a 16x4-bit configuration.
module tb_subseq_sum_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       mode_empty, valid_in;
  logic [7:0] data_in;
  logic       in_ready, valid_out;
  logic [11:0] max_sum;
  logic       mode2, valid2;
  logic [3:0] data2;
  logic       ready2, vout2;
  logic [7:0] sum2;
`ifdef SUBSEQ_IDX_EN
  logic [2:0] start_idx, end_idx;
  logic       idx_valid;
  logic [3:0] s2, e2;
  logic       iv2;
`endif

  subseq_sum_param dut (
    .clk(clk), .rst(rst), .mode_empty(mode_empty),
    .valid_in(valid_in), .data_in(data_in),
    .in_ready(in_ready), .valid_out(valid_out),
    .max_sum(max_sum)
`ifdef SUBSEQ_IDX_EN
    , .start_idx(start_idx), .end_idx(end_idx),
    .idx_valid(idx_valid)
`endif
  );

  subseq_sum_param #(
    .DATA_W(4), .SEQ_LEN(16), .SUM_W(8)
  ) dut2 (
    .clk(clk), .rst(rst), .mode_empty(mode2),
    .valid_in(valid2), .data_in(data2),
    .in_ready(ready2), .valid_out(vout2),
    .max_sum(sum2)
`ifdef SUBSEQ_IDX_EN
    , .start_idx(s2), .end_idx(e2),
    .idx_valid(iv2)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", n, act, exp);
    end
  endtask

  typedef struct {
    int sum;
    int s;
    int e;
    int iv;
  } res_t;

  // Exhaustive search; earliest start, then earliest end, wins ties.
  function automatic res_t ref_max(input int xs[$], input bit m);
    res_t r;
    int a;
    r.sum = m ? 0 : xs[0];
    r.s = 0;
    r.e = 0;
    r.iv = m ? 0 : 1;
    for (int s = 0; s < xs.size(); s++) begin
      a = 0;
      for (int e = s; e < xs.size(); e++) begin
        a += xs[e];
        if (a > r.sum) begin
          r.sum = a;
          r.s = s;
          r.e = e;
          r.iv = 1;
        end
      end
    end
    return r;
  endfunction

  // Cycle model for the default instance.
  int   m_frame[$];
  bit   m_mode;
  bit   m_out = 1'b0;
  res_t m_exp;
  int   pulses = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_valid_out", int'(valid_out), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_max_sum", int'($signed(max_sum)), 0);
`ifdef SUBSEQ_IDX_EN
      chk("rst_idx", int'({start_idx, end_idx, idx_valid}), 0);
`endif
      m_frame.delete();
      m_out = 1'b0;
    end else begin
      chk("in_ready", int'(in_ready), int'(!m_out));
      chk("valid_out", int'(valid_out), int'(m_out));
      if (m_out) begin
        chk("max_sum", int'($signed(max_sum)), m_exp.sum);
`ifdef SUBSEQ_IDX_EN
        chk("start_idx", int'(start_idx), m_exp.s);
        chk("end_idx", int'(end_idx), m_exp.e);
        chk("idx_valid", int'(idx_valid), m_exp.iv);
`endif
        pulses++;
        m_out = 1'b0;
      end else if (valid_in) begin
        if (m_frame.size() == 0) m_mode = mode_empty;
        m_frame.push_back(int'($signed(data_in)));
        if (m_frame.size() == 8) begin
          m_exp = ref_max(m_frame, m_mode);
          m_out = 1'b1;
          m_frame.delete();
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic put(input int x, input bit m, input int gap);
    bit ok;
    bit done;
    done = 1'b0;
    valid_in = 1'b0;
    repeat (gap) cyc();
    valid_in = 1'b1;
    data_in = 8'(x);
    mode_empty = m;
    for (int t = 0; t < 8 && !done; t++) begin
      @(negedge clk);
      ok = in_ready;
      cyc();
      done = ok;
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic frame(input int xs[$], input bit m,
                       input bit gaps, input bit flip);
    foreach (xs[i]) begin
      put(xs[i], (i == 0) ? m : (m ^ flip),
          gaps ? int'($urandom_range(0, 2)) : 0);
    end
  endtask

  task automatic expect_frame(input string n, input int xs[$],
                              input bit m, input bit gaps, input bit flip,
                              input int es, input int ss, input int ee,
                              input int iv);
    res_t r;
    int p0;
    r = ref_max(xs, m);
    chk({n, "_model_sum"}, r.sum, es);
    chk({n, "_model_idx"}, r.s * 100 + r.e * 10 + r.iv,
        ss * 100 + ee * 10 + iv);
    p0 = pulses;
    frame(xs, m, gaps, flip);
    idle(2);
    chk({n, "_pulses"}, pulses - p0, 1);
    chk({n, "_held_sum"}, int'($signed(max_sum)), es);
`ifdef SUBSEQ_IDX_EN
    chk({n, "_held_idx"},
        int'(start_idx) * 100 + int'(end_idx) * 10 + int'(idx_valid),
        ss * 100 + ee * 10 + iv);
`endif
  endtask

  // Second instance: contiguous frame, pulse exactly one cycle later.
  task automatic run2(input string n, input int xs[$], input bit m,
                      input bit has_lit, input int es);
    res_t r;
    r = ref_max(xs, m);
    if (has_lit) chk({n, "_model_sum"}, r.sum, es);
    foreach (xs[i]) begin
      valid2 = 1'b1;
      data2 = 4'(xs[i]);
      mode2 = m;
      @(negedge clk);
      chk({n, "_ready"}, int'(ready2), 1);
      cyc();
    end
    valid2 = 1'b0;
    @(negedge clk);
    chk({n, "_valid_out"}, int'(vout2), 1);
    chk({n, "_max_sum"}, int'($signed(sum2)), r.sum);
`ifdef SUBSEQ_IDX_EN
    chk({n, "_idx"}, int'(s2) * 100 + int'(e2) * 10 + int'(iv2),
        r.s * 100 + r.e * 10 + r.iv);
`endif
    cyc();
    @(negedge clk);
    chk({n, "_pulse_end"}, int'(vout2), 0);
    cyc();
  endtask

  int f[$];
  int g[$];

  initial begin
    rst = 1'b0;
    mode_empty = 1'b0;
    valid_in = 1'b0;
    data_in = '0;
    mode2 = 1'b0;
    valid2 = 1'b0;
    data2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc();

    f = '{-7, 1, -3, 2, -1, 1, 3, -5};
    expect_frame("basic", f, 0, 0, 0, 5, 3, 6, 1);
    expect_frame("basic_gaps", f, 0, 1, 0, 5, 3, 6, 1);

    f = '{-3, -1, -4, -2, -8, -5, -6, -7};
    expect_frame("neg_m0", f, 0, 0, 0, -1, 1, 1, 1);
    expect_frame("neg_m1", f, 1, 1, 0, 0, 0, 0, 0);
    expect_frame("neg_flip", f, 0, 0, 1, -1, 1, 1, 1);

    f = '{127, 127, 127, 127, 127, 127, 127, 127};
    expect_frame("all_max", f, 0, 1, 0, 1016, 0, 7, 1);
    f = '{-128, -128, -128, -128, -128, -128, -128, -128};
    expect_frame("all_min", f, 0, 0, 0, -128, 0, 0, 1);

    f = '{2, -2, 2, -2, 0, 0, 0, 0};
    expect_frame("ties", f, 0, 0, 0, 2, 0, 0, 1);

    // Back-to-back: a sample offered during the result cycle is dropped.
    f = '{-7, 1, -3, 2, -1, 1, 3, -5};
    g = '{1, 2, 3, -10, 4, 5, -1, 2};
    frame(f, 0, 0, 0);
    valid_in = 1'b1;
    data_in = 8'(99);
    cyc();
    expect_frame("b2b", g, 0, 0, 0, 10, 4, 7, 1);

    // Abort a partial frame with reset.
    f = '{5, 5, 5, 5};
    frame(f, 0, 0, 0);
    idle(1);
    #1 rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    expect_frame("after_rst", g, 0, 1, 0, 10, 4, 7, 1);

    f = '{2, -2, 2, -2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run2("w16_ties", f, 0, 1, 2);
    run2("w16_ties_m1", f, 1, 1, 2);
    f = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    run2("w16_max", f, 0, 1, 112);
    f = '{-8, -8, -8, -8, -8, -8, -8, -8,
          -8, -8, -8, -8, -8, -8, -8, -8};
    run2("w16_min", f, 0, 1, -8);
    for (int k = 0; k < 4; k++) begin
      f.delete();
      for (int i = 0; i < 16; i++) f.push_back(int'($urandom_range(0, 15)) - 8);
      run2("w16_rand", f, k[0], 0, 0);
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
